// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch-side defaults and the fetched (pc, instr) packet type
package core_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          INSTR_W_DEF  = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam int          PC_STEP_DEF  = 4;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0]  pc;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch-to-decode valid/ready handshake carrying (pc, instr)
interface instr_fetch_if
    import core_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);

    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] out_instr;

    modport master (
        output out_valid,
        output out_pc,
        output out_instr,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_pc,
        input  out_instr,
        output out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - 2-entry registered FIFO; head is always entry 0, flush beats push and pop
module fetch_fifo
    import core_pkg::*;
#(
    parameter type  pkt_t     = fetch_pkt_t,
    parameter pkt_t RESET_VAL = '0
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  pkt_t       din,
    output logic [1:0] count,
    output pkt_t       head
);

    pkt_t       e0_q, e0_d;
    pkt_t       e1_q, e1_d;
    logic [1:0] count_q, count_d;
    logic       pop_ok;

    assign pop_ok = pop && (count_q != 2'd0);

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        e0_d    = din;
                        count_d = 2'd1;
                    end else begin
                        e1_d    = din;
                        count_d = 2'd2;
                    end
                end
                2'b01: begin
                    e0_d    = e1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged: head retires, the new packet lands behind any survivor
                    if (count_q == 2'd2) begin
                        e0_d = e1_q;
                        e1_d = din;
                    end else begin
                        e0_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            e0_q    <= RESET_VAL;
            e1_q    <= RESET_VAL;
            count_q <= 2'd0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = e0_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC owner and InstrMem initiator delivering (pc, instr) pairs to decode
module instr_fetch
    import core_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int                PC_STEP  = PC_STEP_DEF
) (
    input  logic               clock,
    input  logic               resetn,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    instr_fetch_if.master      out_if
);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } pkt_t;

    localparam pkt_t RESET_PKT = '{pc: RESET_PC, instr: '0};

    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;

    logic [1:0] count;
    logic [2:0] occupancy;
    logic       pop;
    logic       push;
    logic       issue;
    pkt_t       head;
    pkt_t       push_pkt;

    assign pop       = out_if.out_valid & out_if.out_ready;
    assign occupancy = {1'b0, count} + {2'b00, inflight_q};
    // Issue only when the response is guaranteed a FIFO slot once it returns
    assign issue     = !redirect_valid && (occupancy < (3'd2 + {2'b00, pop}));
    assign push      = inflight_q && !redirect_valid;
    assign push_pkt  = '{pc: inflight_pc_q, instr: imem_instr};

    always_comb begin
        imem_addr_d   = imem_addr_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            imem_addr_d = redirect_pc;
        end else if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = imem_addr_q;
            imem_addr_d   = imem_addr_q + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            imem_addr_q   <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            imem_addr_q   <= imem_addr_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .pkt_t     (pkt_t),
        .RESET_VAL (RESET_PKT)
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .flush  (redirect_valid),
        .din    (push_pkt),
        .count  (count),
        .head   (head)
    );

    assign imem_addr        = imem_addr_q;
    assign out_if.out_valid = (count != 2'd0);
    assign out_if.out_pc    = head.pc;
    assign out_if.out_instr = head.instr;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench: directed scenarios plus randomized ready/redirect traffic
module tb_instr_fetch;

    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    instr_fetch_if #(.ADDR_W(32), .INSTR_W(32)) out_if ();

    instr_fetch #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (RPC),
        .PC_STEP  (4)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_if         (out_if)
    );

    always #5 clock = ~clock;

    always @(posedge clock) imem_instr <= imem_addr ^ KEY;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] next_exp_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: next_exp_pc, instr: next_exp_pc ^ KEY});
            next_exp_pc += 32'd4;
        end
    endfunction

    function automatic void restart(input logic [31:0] pc);
        exp_q.delete();
        next_exp_pc = pc;
        top_up();
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        top_up();
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        restart(pc);
        step();
        redirect_valid = 1'b0;
    endtask

    logic        hold = 1'b0;
    logic [31:0] h_pc, h_instr;

    always @(negedge clock) begin : monitor
        exp_t e;
        if (!resetn) begin
            chk("valid_in_reset", {31'b0, out_if.out_valid}, 32'd0);
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("stall_valid", {31'b0, out_if.out_valid}, 32'd1);
                chk("stall_pc", out_if.out_pc, h_pc);
                chk("stall_instr", out_if.out_instr, h_instr);
            end
            hold = 1'b0;
            if (!redirect_valid && out_if.out_valid) begin
                if (out_if.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty: got pc %h expected no pair", out_if.out_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_pc", out_if.out_pc, e.pc);
                        chk("sb_instr", out_if.out_instr, e.instr);
                    end
                end else begin
                    hold    = 1'b1;
                    h_pc    = out_if.out_pc;
                    h_instr = out_if.out_instr;
                end
            end
        end
    end

    initial begin
        out_if.out_ready = 1'b0;
        restart(RPC);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_addr", imem_addr, RPC);
        chk("rst_valid", {31'b0, out_if.out_valid}, 32'd0);
        chk("rst_pc", out_if.out_pc, RPC);
        chk("rst_instr", out_if.out_instr, 32'd0);

        // Reset release, decode stalled for the first pair
        resetn = 1'b1;
        step();
        chk("e1_addr", imem_addr, RPC + 32'd4);
        chk("e1_valid", {31'b0, out_if.out_valid}, 32'd0);
        step();
        chk("e2_valid", {31'b0, out_if.out_valid}, 32'd1);
        chk("e2_pc", out_if.out_pc, RPC);
        chk("e2_instr", out_if.out_instr, 32'h25A5_0000);
        repeat (5) begin
            step();
            chk("stall_head", out_if.out_pc, RPC);
        end
        chk("stall_addr", imem_addr, RPC + 32'd8);

        out_if.out_ready = 1'b1;
        step();
        chk("rel_pc1", out_if.out_pc, RPC + 32'd4);
        step();
        chk("rel_pc2", out_if.out_pc, RPC + 32'd8);
        chk("rel_valid2", {31'b0, out_if.out_valid}, 32'd1);
        repeat (4) step();

        // Redirect with the FIFO full
        out_if.out_ready = 1'b0;
        repeat (4) step();
        chk("full_valid", {31'b0, out_if.out_valid}, 32'd1);
        do_redirect(32'h8000_1000);
        chk("rd_e0_valid", {31'b0, out_if.out_valid}, 32'd0);
        step();
        chk("rd_e1_valid", {31'b0, out_if.out_valid}, 32'd0);
        step();
        chk("rd_e2_valid", {31'b0, out_if.out_valid}, 32'd1);
        chk("rd_e2_pc", out_if.out_pc, 32'h8000_1000);
        chk("rd_e2_instr", out_if.out_instr, 32'h8000_1000 ^ KEY);
        out_if.out_ready = 1'b1;
        repeat (6) step();

        // Redirect coinciding with a pop, then back-to-back redirects
        chk("pop_valid", {31'b0, out_if.out_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_2000;
        restart(32'h8000_2000);
        step();
        redirect_pc = 32'h8000_3000;
        restart(32'h8000_3000);
        step();
        redirect_valid = 1'b0;
        chk("b2b_e0_valid", {31'b0, out_if.out_valid}, 32'd0);
        step();
        chk("b2b_e1_valid", {31'b0, out_if.out_valid}, 32'd0);
        step();
        chk("b2b_pc", out_if.out_pc, 32'h8000_3000);
        repeat (6) step();

        // Address wrap
        do_redirect(32'hFFFF_FFFC);
        step();
        step();
        chk("wrap_pc0", out_if.out_pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc1", out_if.out_pc, 32'h0000_0000);
        chk("wrap_instr1", out_if.out_instr, KEY);
        repeat (4) step();

        // Reset mid-stream
        resetn = 1'b0;
        restart(RPC);
        #1;
        chk("mid_rst_valid", {31'b0, out_if.out_valid}, 32'd0);
        chk("mid_rst_addr", imem_addr, RPC);
        step();
        step();
        resetn = 1'b1;
        step();
        step();
        chk("mid_rst_pc", out_if.out_pc, RPC);
        chk("mid_rst_vld", {31'b0, out_if.out_valid}, 32'd1);
        repeat (4) step();

        // Random ready with occasional redirects
        repeat (10000) begin
            out_if.out_ready = 1'($urandom % 2);
            if (($urandom % 64) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
                restart(redirect_pc);
            end else begin
                redirect_valid = 1'b0;
            end
            step();
        end
        redirect_valid   = 1'b0;
        out_if.out_ready = 1'b1;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
